lab2_proc_imem_flush_filter: RTL and testbench

Parametrised successor to the single-drop imem response drop unit. It sits between the fetch-side request/response handshakes and the instruction memory. It tracks up to p_max_inflight outstanding imem requests. On a squash, it discards every response that belongs to a request issued before the squash, however many there are. Responses are never reordered, and the block applies request-side backpressure when the in-flight limit is reached.

---
 rtl/lab2_proc_imem_flush_filter.sv | 93 +++++++++
 tb/tb_lab2_proc_imem_flush_filter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_imem_flush_filter.sv
// imem response filter: tracks outstanding fetches and drops squashed responses.
// Ports: fetch req/resp handshakes, imem req/resp handshakes, squash, counters.
module lab2_proc_imem_flush_filter #(
    parameter int p_msg_nbits    = 47,
    parameter int p_max_inflight = 2,
    localparam int c_cnt_nbits   = $clog2(p_max_inflight + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    input  logic                   squash,
    input  logic [p_msg_nbits-1:0] in_msg,
    input  logic                   in_val,
    output logic                   in_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [c_cnt_nbits-1:0] num_inflight,
    output logic [c_cnt_nbits-1:0] num_to_drop,
    output logic [31:0]            num_dropped
);

    localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_max_inflight);

    logic [c_cnt_nbits-1:0] r_inflight;
    logic [c_cnt_nbits-1:0] r_to_drop;
    logic [31:0]            r_dropped;

    logic w_space;
    logic w_req_fire;
    logic w_drop_now;
    logic w_resp_fire;
    logic w_drop_fire;

    // Full tracker blocks requests even if a response retires this cycle.
    assign w_space     = (r_inflight < c_max);
    assign mem_req_val = req_val & w_space;
    assign req_rdy     = mem_req_rdy & w_space;
    assign w_req_fire  = req_val & req_rdy;

    assign w_drop_now = in_val & ((r_to_drop != '0) | squash);

    always_comb begin
        in_rdy  = 1'b0;
        out_val = 1'b0;
        if (r_inflight == '0) begin
            in_rdy  = 1'b0;
            out_val = 1'b0;
        end else if (w_drop_now) begin
            in_rdy  = 1'b1;
            out_val = 1'b0;
        end else begin
            in_rdy  = out_rdy;
            out_val = in_val;
        end
    end

    assign out_msg     = in_msg;
    assign w_resp_fire = in_val & in_rdy;
    assign w_drop_fire = w_resp_fire & w_drop_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_to_drop  <= '0;
            r_dropped  <= '0;
        end else begin
            r_inflight <= r_inflight
                        + c_cnt_nbits'(w_req_fire)
                        - c_cnt_nbits'(w_resp_fire);
            // A request firing with squash is the redirected fetch: not dropped.
            if (squash)
                r_to_drop <= r_inflight - c_cnt_nbits'(w_resp_fire);
            else
                r_to_drop <= r_to_drop - c_cnt_nbits'(w_drop_fire);
            if (w_drop_fire)
                r_dropped <= r_dropped + 32'd1;
        end
    end

    assign num_inflight = r_inflight;
    assign num_to_drop  = r_to_drop;
    assign num_dropped  = r_dropped;

    a_inflight_max: assert property (
        @(posedge clk) disable iff (reset) r_inflight <= c_max);
    a_drop_le_inflight: assert property (
        @(posedge clk) disable iff (reset) r_to_drop <= r_inflight);

endmodule

// File: tb/tb_lab2_proc_imem_flush_filter.sv
// Scoreboard bench for lab2_proc_imem_flush_filter.
// Delivered responses are queued when driven and popped at output handshake.
module tb_lab2_proc_imem_flush_filter;

    localparam int W  = 47;
    localparam int CN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val;
    logic          req_rdy;
    logic          mem_req_val;
    logic          mem_req_rdy;
    logic          squash;
    logic [W-1:0]  in_msg;
    logic          in_val;
    logic          in_rdy;
    logic [W-1:0]  out_msg;
    logic          out_val;
    logic          out_rdy;
    logic [CN-1:0] num_inflight;
    logic [CN-1:0] num_to_drop;
    logic [31:0]   num_dropped;

    int n_checks = 0;
    int n_errors = 0;
    int n_deliv  = 0;
    logic [W-1:0] sb_q[$];

    lab2_proc_imem_flush_filter #(
        .p_msg_nbits(W),
        .p_max_inflight(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_val(req_val),
        .req_rdy(req_rdy),
        .mem_req_val(mem_req_val),
        .mem_req_rdy(mem_req_rdy),
        .squash(squash),
        .in_msg(in_msg),
        .in_val(in_val),
        .in_rdy(in_rdy),
        .out_msg(out_msg),
        .out_val(out_val),
        .out_rdy(out_rdy),
        .num_inflight(num_inflight),
        .num_to_drop(num_to_drop),
        .num_dropped(num_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cnt(input string tag, input int i, input int d,
                       input int n);
        chk({tag, "_I"}, 64'(num_inflight), 64'(i));
        chk({tag, "_D"}, 64'(num_to_drop), 64'(d));
        chk({tag, "_N"}, 64'(num_dropped), 64'(n));
    endtask

    task automatic resp(input logic [W-1:0] m, input bit deliver);
        in_val = 1'b1;
        in_msg = m;
        if (deliver) sb_q.push_back(m);
    endtask

    // Output monitor: handshake is evaluated mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (!reset && out_val && out_rdy) begin
            n_deliv++;
            if (sb_q.size() == 0)
                chk("sb_unexpected", 64'(out_msg), 64'h0);
            else
                chk("sb_msg", 64'(out_msg), 64'(sb_q.pop_front()));
        end
    end

    initial begin
        reset = 1'b1;
        req_val = 1'b0;
        mem_req_rdy = 1'b1;
        squash = 1'b0;
        in_msg = '0;
        in_val = 1'b0;
        out_rdy = 1'b1;
        #2;
        cnt("rst", 0, 0, 0);
        step();
        reset = 1'b0;

        // back-to-back requests hit the limit of 2
        req_val = 1'b1;
        #1 chk("t1_rdy0", 64'(req_rdy), 64'd1);
        step();
        chk("t1_rdy1", 64'(req_rdy), 64'd1);
        step();
        chk("t1_full_rdy", 64'(req_rdy), 64'd0);
        chk("t1_full_mval", 64'(mem_req_val), 64'd0);
        chk("t1_I", 64'(num_inflight), 64'd2);
        step();
        chk("t1_held", 64'(num_inflight), 64'd2);
        resp(47'h01, 1'b1);
        #1 chk("t1_still_blk", 64'(req_rdy), 64'd0);
        step();
        in_val = 1'b0;
        chk("t1_after_resp", 64'(num_inflight), 64'd1);
        chk("t1_rdy_back", 64'(req_rdy), 64'd1);
        step();
        req_val = 1'b0;
        cnt("t1_end", 2, 0, 0);

        // squash with no response, then two dropped and one delivered
        squash = 1'b1;
        step();
        squash = 1'b0;
        cnt("t2_sq", 2, 2, 0);
        resp(47'h11, 1'b0);
        #1 chk("t2_ov0", 64'(out_val), 64'd0);
        chk("t2_ir0", 64'(in_rdy), 64'd1);
        step();
        cnt("t2_d1", 1, 1, 1);
        resp(47'h22, 1'b0);
        req_val = 1'b1;
        #1 chk("t2_ov1", 64'(out_val), 64'd0);
        step();
        req_val = 1'b0;
        cnt("t2_d0", 1, 0, 2);
        resp(47'h33, 1'b1);
        #1 chk("t2_ov2", 64'(out_val), 64'd1);
        step();
        in_val = 1'b0;
        chk("t2_end", 64'(num_inflight), 64'd0);

        // squash coincident with a response
        req_val = 1'b1;
        step();
        step();
        req_val = 1'b0;
        squash = 1'b1;
        resp(47'hAA, 1'b0);
        #1 chk("t3_ov", 64'(out_val), 64'd0);
        chk("t3_ir", 64'(in_rdy), 64'd1);
        step();
        squash = 1'b0;
        cnt("t3_a", 1, 1, 3);
        resp(47'hBB, 1'b0);
        #1 chk("t3_ov2", 64'(out_val), 64'd0);
        step();
        in_val = 1'b0;
        cnt("t3_b", 0, 0, 4);

        // squash coincident with a request fire
        req_val = 1'b1;
        step();
        squash = 1'b1;
        step();
        squash = 1'b0;
        req_val = 1'b0;
        cnt("t4_a", 2, 1, 4);
        resp(47'hC1, 1'b0);
        step();
        cnt("t4_b", 1, 0, 5);
        resp(47'hC2, 1'b1);
        #1 chk("t4_ov", 64'(out_val), 64'd1);
        step();
        in_val = 1'b0;
        chk("t4_end", 64'(num_inflight), 64'd0);

        // fetch backpressure
        req_val = 1'b1;
        step();
        req_val = 1'b0;
        out_rdy = 1'b0;
        resp(47'hD5, 1'b0);
        #1 chk("t5_ir", 64'(in_rdy), 64'd0);
        chk("t5_ov", 64'(out_val), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_I", 64'(num_inflight), 64'd1);
            chk("t5_msg", 64'(out_msg), 64'hD5);
        end
        sb_q.push_back(47'hD5);
        out_rdy = 1'b1;
        step();
        in_val = 1'b0;
        chk("t5_end", 64'(num_inflight), 64'd0);

        // response with nothing outstanding
        resp(47'hEE, 1'b0);
        #1 chk("t6_ir", 64'(in_rdy), 64'd0);
        chk("t6_ov", 64'(out_val), 64'd0);
        step();
        in_val = 1'b0;
        cnt("t6", 0, 0, 5);

        // asynchronous reset mid-operation
        req_val = 1'b1;
        step();
        squash = 1'b1;
        step();
        squash = 1'b0;
        req_val = 1'b0;
        cnt("t7_pre", 2, 1, 5);
        #2 reset = 1'b1;
        #1 cnt("t7_rst", 0, 0, 0);
        step();
        reset = 1'b0;
        step();

        chk("sb_left", 64'(sb_q.size()), 64'd0);
        chk("sb_count", 64'(n_deliv), 64'd4);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
